// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf result collector.
//   RESULT_W / ADDR_W / SEQ_W : leaf result layout {addr, seq}
//   RES_*_MSB/LSB             : field slice positions inside a leaf result
//   state_t                   : collector FSM encoding
package leaf_pkg;
    localparam int ADDR_W       = 3;
    localparam int SEQ_W        = 32;
    localparam int RESULT_W     = ADDR_W + SEQ_W;
    localparam int RES_ADDR_MSB = 34;
    localparam int RES_ADDR_LSB = 32;
    localparam int RES_SEQ_MSB  = 31;
    localparam int RES_SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/leaf_result_collector_next_leaf_sel.sv
// Combinational priority finder over the received-leaf mask.
//   mask      : received-leaf bitmap, bit 0 is never set
//   ptr       : last address sent (0 = nothing sent yet)
//   next_addr : lowest set mask bit strictly above ptr (0 when none)
//   found     : next_addr is valid
//   is_last   : no set mask bit above next_addr
module next_leaf_sel #(
    parameter int ADDR_W = leaf_pkg::ADDR_W
) (
    input  logic [(1<<ADDR_W)-1:0] mask,
    input  logic [ADDR_W-1:0]      ptr,
    output logic [ADDR_W-1:0]      next_addr,
    output logic                   found,
    output logic                   is_last
);
    localparam int N = 1 << ADDR_W;

    always_comb begin
        next_addr = '0;
        found     = 1'b0;
        // Descending scan so the lowest qualifying bit is the final winner.
        for (int i = N - 1; i >= 1; i--) begin
            if (mask[i] && (i > int'(ptr))) begin
                next_addr = ADDR_W'(i);
                found     = 1'b1;
            end
        end
        is_last = found;
        for (int j = 1; j < N; j++) begin
            if (mask[j] && (j > int'(next_addr))) is_last = 1'b0;
        end
    end
endmodule

// File: rtl/leaf_result_collector.sv
// Captures PE-array leaf results once per address, then streams them out in
// ascending address order over valid/ready.
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a run (only honoured in IDLE)
//   expected_leaves  : distinct leaves to wait for, clamped to 2^ADDR_W-1
//   leaf_result      : {addr, seq}; zero means no result
//   out_valid/ready  : output handshake; out_addr/out_seq/out_last payload
//   done             : one-cycle end-of-run pulse
//   busy             : collecting or draining
//   timeout_err      : run ended by idle timeout (sticky until next start)
//   dup_count        : saturating count of repeats for stored addresses
module leaf_result_collector #(
    parameter int ADDR_W  = leaf_pkg::ADDR_W,
    parameter int SEQ_W   = leaf_pkg::SEQ_W,
    parameter int TIMEOUT = 1024,
    parameter int DUP_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W:0]         expected_leaves,
    input  logic [ADDR_W+SEQ_W-1:0] leaf_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [SEQ_W-1:0]        out_seq,
    output logic                    out_last,
    output logic                    done,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [DUP_W-1:0]        dup_count
);
    import leaf_pkg::*;

    localparam int NUM_LEAF = (1 << ADDR_W) - 1;
    localparam int IDLE_W   = $clog2(TIMEOUT) + 1;

    state_t                state, next_state;
    logic [NUM_LEAF:0]     rx_mask;
    logic [SEQ_W-1:0]      regfile [1:NUM_LEAF];
    logic [IDLE_W-1:0]     idle_cnt;
    logic [ADDR_W:0]       exp_reg, leaf_cnt, exp_clamp;

    logic [ADDR_W-1:0]     res_addr;
    logic [SEQ_W-1:0]      res_seq;
    logic                  complete, accept, dup, tmo, handshake;
    logic [ADDR_W-1:0]     sel_ptr, sel_addr;
    logic                  sel_found, sel_last;

    assign res_addr  = leaf_result[SEQ_W +: ADDR_W];
    assign res_seq   = leaf_result[SEQ_W-1:0];
    assign exp_clamp = (expected_leaves > (ADDR_W+1)'(NUM_LEAF)) ? (ADDR_W+1)'(NUM_LEAF)
                                                                 : expected_leaves;

    // leaf_cnt mirrors popcount(rx_mask) as a register.
    assign complete  = (state == COLLECT) && (leaf_cnt == exp_reg);
    assign dup       = (state == COLLECT) && (res_addr != '0) && rx_mask[res_addr];
    assign accept    = (state == COLLECT) && !complete && (res_addr != '0) && !rx_mask[res_addr];
    assign tmo       = (state == COLLECT) && !complete && !accept &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign handshake = out_valid && out_ready;

    // Outside DRAIN the scan starts from address 0 so the first word is ready
    // to load on the transition edge; inside DRAIN the last sent address is out_addr.
    assign sel_ptr = (state == DRAIN) ? out_addr : '0;

    next_leaf_sel #(.ADDR_W(ADDR_W)) u_sel (
        .mask      (rx_mask),
        .ptr       (sel_ptr),
        .next_addr (sel_addr),
        .found     (sel_found),
        .is_last   (sel_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (exp_clamp == '0) ? DONE : COLLECT;
            COLLECT: begin
                if (complete)  next_state = DRAIN;
                else if (tmo)  next_state = (rx_mask == '0) ? DONE : DRAIN;
            end
            DRAIN:   if (handshake && out_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        busy = (state == COLLECT) || (state == DRAIN);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_mask     <= '0;
            idle_cnt    <= '0;
            dup_count   <= '0;
            exp_reg     <= '0;
            leaf_cnt    <= '0;
            timeout_err <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_seq     <= '0;
            out_last    <= 1'b0;
            for (int i = 1; i <= NUM_LEAF; i++) regfile[i] <= '0;
        end else begin
            done <= (state == DONE);

            if (state == IDLE && start) begin
                rx_mask     <= '0;
                idle_cnt    <= '0;
                dup_count   <= '0;
                leaf_cnt    <= '0;
                timeout_err <= 1'b0;
                exp_reg     <= exp_clamp;
            end

            if (accept) begin
                regfile[res_addr]  <= res_seq;
                rx_mask[res_addr]  <= 1'b1;
                leaf_cnt           <= leaf_cnt + (ADDR_W+1)'(1);
                idle_cnt           <= '0;
            end else if (state == COLLECT) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (dup && (dup_count != '1)) dup_count <= dup_count + DUP_W'(1);
            if (tmo) timeout_err <= 1'b1;

            // Load the first word on entry, the next one on each handshake.
            if ((state == COLLECT && next_state == DRAIN) ||
                (state == DRAIN && handshake && !out_last)) begin
                out_valid <= 1'b1;
                out_addr  <= sel_addr;
                out_seq   <= sel_found ? regfile[sel_addr] : '0;
                out_last  <= sel_last;
            end else if (state == DRAIN && handshake) begin
                out_valid <= 1'b0;
                out_addr  <= '0;
                out_seq   <= '0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule
